// File: rtl/ws2812_pkg.sv
// Shared state encoding, default timing and ns-to-cycle conversion for the WS2812 receiver.
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      CHECK = 2'd2,
      FULL  = 2'd3
   } state_e;

   localparam int DEF_CLK_PRD_NS = 50;
   localparam int DEF_BITS       = 24;
   localparam int DEF_T0H_NS     = 350;
   localparam int DEF_T1H_NS     = 700;
   localparam int DEF_MARGIN_NS  = 150;
   localparam int DEF_RET_NS     = 50000;

   function automatic int ns_to_cyc(input int ns, input int clk_prd_ns);
      return ns / clk_prd_ns;
   endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Synchronises the chain input and measures high-pulse length and low-gap length.
// Outputs lag i_serial by two clocks; no backpressure, counters run every cycle.
module ws2812_pulse_meas
   import ws2812_pkg::*;
#(
   parameter int HCW     = 5,
   parameter int RST_CYC = 1000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_serial,
   input  logic           high_load,
   input  logic           high_inc,
   output logic           s_in,
   output logic [HCW-1:0] high_cnt,
   output logic           fall,
   output logic           gap
);

   localparam int GCW = $clog2(RST_CYC + 1);
   localparam logic [GCW-1:0] GAP_MAX  = GCW'(RST_CYC);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(RST_CYC - 1);
   localparam logic [HCW-1:0] HIGH_SAT = '1;

   logic           sync1_q, sync1_d;
   logic           sync2_q, sync2_d;
   logic           prev_q, prev_d;
   logic [HCW-1:0] high_q, high_d;
   logic [GCW-1:0] gap_q, gap_d;

   always_comb begin
      sync1_d = i_serial;
      sync2_d = sync1_q;
      prev_d  = sync2_q;

      high_d = high_q;
      if (high_load) begin
         high_d = HCW'(1);
      end else if (high_inc && (high_q != HIGH_SAT)) begin
         high_d = high_q + HCW'(1);
      end

      // Saturated count stays put so a long idle line raises gap only once.
      gap_d = gap_q;
      if (sync2_q) begin
         gap_d = '0;
      end else if (gap_q != GAP_MAX) begin
         gap_d = gap_q + GCW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         high_q  <= '0;
         gap_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         high_q  <= high_d;
         gap_q   <= gap_d;
      end
   end

   assign s_in     = sync2_q;
   assign high_cnt = high_q;
   assign fall     = prev_q & ~sync2_q;
   assign gap      = ~sync2_q && (gap_q == GAP_LAST);

endmodule

// File: rtl/ws2812_rx.sv
// One daisy-chain node: decodes the first BITS pulses after a reset gap, forwards the rest.
// Final bit shows on o_led/o_valid 4 clocks after its fall; no backpressure, o_serial is combinational.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int CLK_PRD_NS = DEF_CLK_PRD_NS,
   parameter int BITS       = DEF_BITS,
   parameter int T0H_NS     = DEF_T0H_NS,
   parameter int T1H_NS     = DEF_T1H_NS,
   parameter int MARGIN_NS  = DEF_MARGIN_NS,
   parameter int RET_NS     = DEF_RET_NS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_serial,
   output logic            o_serial,
   output logic [BITS-1:0] o_led,
   output logic            o_valid,
   output logic            o_err
);

   localparam int T0H_MIN = ns_to_cyc(T0H_NS - MARGIN_NS, CLK_PRD_NS);
   localparam int T0H_MAX = ns_to_cyc(T0H_NS + MARGIN_NS, CLK_PRD_NS);
   localparam int T1H_MIN = ns_to_cyc(T1H_NS - MARGIN_NS, CLK_PRD_NS);
   localparam int T1H_MAX = ns_to_cyc(T1H_NS + MARGIN_NS, CLK_PRD_NS);
   localparam int RST_CYC = ns_to_cyc(RET_NS, CLK_PRD_NS);
   localparam int HCW     = $clog2(T1H_MAX + 2);
   localparam int BCW     = $clog2(BITS + 1);

   localparam logic [HCW-1:0] T0_MIN_C = HCW'(T0H_MIN);
   localparam logic [HCW-1:0] T0_MAX_C = HCW'(T0H_MAX);
   localparam logic [HCW-1:0] T1_MIN_C = HCW'(T1H_MIN);
   localparam logic [HCW-1:0] T1_MAX_C = HCW'(T1H_MAX);
   localparam logic [BCW-1:0] BITS_C   = BCW'(BITS);

   if (T0H_MAX >= T1H_MIN) begin : g_bad_windows
      $fatal(1, "ws2812_rx: 0-bit and 1-bit high-time windows overlap");
   end
   if (T0H_MIN < 1) begin : g_bad_t0min
      $fatal(1, "ws2812_rx: minimum 0-bit high time is below one clock");
   end
   if ((BITS != 24) && (BITS != 32)) begin : g_bad_bits
      $fatal(1, "ws2812_rx: BITS must be 24 or 32");
   end

   state_e          state_q, state_d;
   logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BITS-1:0] shift_q, shift_d;
   logic [BITS-1:0] led_q, led_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic            s_in, fall, gap;
   logic [HCW-1:0]  high_cnt;
   logic            high_load, high_inc;
   logic            bit_v, bad_v;

   assign high_load = (state_q == IDLE) && s_in && (bit_cnt_q < BITS_C);
   assign high_inc  = (state_q == HIGH) && s_in;

   ws2812_pulse_meas #(
      .HCW     (HCW),
      .RST_CYC (RST_CYC)
   ) u_meas (
      .clk       (clk),
      .rst       (rst),
      .i_serial  (i_serial),
      .high_load (high_load),
      .high_inc  (high_inc),
      .s_in      (s_in),
      .high_cnt  (high_cnt),
      .fall      (fall),
      .gap       (gap)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      led_d     = led_q;
      valid_d   = 1'b0;
      err_d     = err_q;
      bit_v     = 1'b0;
      bad_v     = 1'b0;

      case (state_q)
         IDLE: begin
            if (high_load) state_d = HIGH;
         end
         HIGH: begin
            if (fall) state_d = CHECK;
         end
         CHECK: begin
            // Out-of-window pulses are stored as 0 so the frame keeps its bit alignment.
            bit_v = (high_cnt >= T1_MIN_C) && (high_cnt <= T1_MAX_C);
            bad_v = !bit_v && !((high_cnt >= T0_MIN_C) && (high_cnt <= T0_MAX_C));
            shift_d   = shift_q | ({{(BITS-1){1'b0}}, bit_v} << (BITS_C - BCW'(1) - bit_cnt_q));
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bad_v) err_d = 1'b1;
            if (bit_cnt_q == BITS_C - BCW'(1)) begin
               led_d   = shift_d;
               valid_d = 1'b1;
            end
            state_d = (bit_cnt_d == BITS_C) ? FULL : IDLE;
         end
         FULL: begin
            state_d = FULL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A latch gap restarts the node; o_led deliberately keeps the last pixel.
      if (gap) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         if ((bit_cnt_q != '0) && (bit_cnt_q != BITS_C)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         led_q     <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         led_q     <= led_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign o_serial = (state_q == FULL) & i_serial;
   assign o_led    = led_q;
   assign o_valid  = valid_q;
   assign o_err    = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised bench for ws2812_rx: a pulse-level reference model feeds a scoreboard popped on o_valid.
module tb_ws2812_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser24 = 1'b0, ser32 = 1'b0;
   logic        oser24, oser32, val24, val32, err24, err32;
   logic [23:0] led24;
   logic [31:0] led32;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t q24[$];
   exp_t q32[$];
   exp_t mon_e;

   // Timing windows worked out by hand from the ns parameters of each instance.
   int nb    [2] = '{24, 32};
   int t0min [2] = '{4, 10};
   int t0max [2] = '{10, 25};
   int t1min [2] = '{11, 27};
   int t1max [2] = '{17, 42};
   int nom0  [2] = '{7, 17};
   int nom1  [2] = '{14, 35};
   int rstc  [2] = '{1000, 2500};

   int          mcnt  [2];
   logic [31:0] mword [2];
   logic        merr  [2];
   logic [31:0] last_led [2];

   ws2812_rx dut24 (
      .clk      (clk),
      .rst      (rst),
      .i_serial (ser24),
      .o_serial (oser24),
      .o_led    (led24),
      .o_valid  (val24),
      .o_err    (err24)
   );

   ws2812_rx #(
      .CLK_PRD_NS (20),
      .BITS       (32)
   ) dut32 (
      .clk      (clk),
      .rst      (rst),
      .i_serial (ser32),
      .o_serial (oser32),
      .o_led    (led32),
      .o_valid  (val32),
      .o_err    (err32)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic get_oser(input int s);
      return (s != 0) ? oser32 : oser24;
   endfunction

   function automatic logic get_err(input int s);
      return (s != 0) ? err32 : err24;
   endfunction

   function automatic logic [31:0] get_led(input int s);
      return (s != 0) ? led32 : {8'h00, led24};
   endfunction

   task automatic set_ser(input int s, input logic v);
      if (s != 0) ser32 = v;
      else        ser24 = v;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         mcnt[i]     = 0;
         mword[i]    = '0;
         merr[i]     = 1'b0;
         last_led[i] = '0;
      end
   endtask

   // One high pulse of hi clocks followed by lo clocks of low line.
   task automatic send_pulse(input int s, input int hi, input int lo);
      logic was_full;
      logic b;
      int   fc;
      exp_t ev;
      was_full = (mcnt[s] == nb[s]);
      @(posedge clk);
      #1 set_ser(s, 1'b1);
      #1 check("serial_mirror", 32'(get_oser(s)), 32'(was_full));
      repeat (hi) @(posedge clk);
      #1 set_ser(s, 1'b0);
      fc = cyc;
      if (!was_full) begin
         if (hi >= t1min[s] && hi <= t1max[s]) begin
            b = 1'b1;
         end else begin
            b = 1'b0;
            if (!(hi >= t0min[s] && hi <= t0max[s])) merr[s] = 1'b1;
         end
         mword[s][nb[s]-1-mcnt[s]] = b;
         mcnt[s]++;
         if (mcnt[s] == nb[s]) begin
            ev.data = mword[s];
            ev.at   = fc + 4;
            last_led[s] = mword[s];
            if (s != 0) q32.push_back(ev);
            else        q24.push_back(ev);
         end
      end
      if (lo >= rstc[s]) begin
         repeat (lo + 2) @(posedge clk);
         if (mcnt[s] > 0 && mcnt[s] < nb[s]) merr[s] = 1'b1;
         mcnt[s]  = 0;
         mword[s] = '0;
      end else begin
         repeat (lo - 1) @(posedge clk);
      end
   endtask

   function automatic int rand_hi(input int s, input logic b);
      return b ? int'($urandom_range(t1max[s], t1min[s])) : int'($urandom_range(t0max[s], t0min[s]));
   endfunction

   // Sends the top nbits of a pixel word; bit k gets long_lo after it, the last gets last_lo.
   task automatic send_word(input int s, input logic [31:0] w, input int nbits, input bit fixed,
                            input int long_idx, input int long_lo, input int last_lo);
      for (int k = 0; k < nbits; k++) begin
         logic b;
         int   hi;
         int   lo;
         b  = w[nb[s]-1-k];
         hi = fixed ? (b ? nom1[s] : nom0[s]) : rand_hi(s, b);
         lo = int'($urandom_range(20, 4));
         if (k == long_idx)  lo = long_lo;
         if (k == nbits - 1) lo = last_lo;
         send_pulse(s, hi, lo);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_led24",  get_led(0), 32'h0);
      check("rst_err24",  32'(err24), 32'h0);
      check("rst_val24",  32'(val24), 32'h0);
      check("rst_ser24",  32'(oser24), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
   endtask

   always @(negedge clk) begin
      if (val24) begin
         if (q24.size() == 0) begin
            check("valid24_unexpected", 32'h1, 32'h0);
         end else begin
            mon_e = q24.pop_front();
            check("led24", {8'h00, led24}, mon_e.data);
            check("latency24", 32'(cyc), 32'(mon_e.at));
         end
      end
      if (val32) begin
         if (q32.size() == 0) begin
            check("valid32_unexpected", 32'h1, 32'h0);
         end else begin
            mon_e = q32.pop_front();
            check("led32", led32, mon_e.data);
            check("latency32", 32'(cyc), 32'(mon_e.at));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset_led24",  get_led(0), 32'h0);
      check("reset_val24",  32'(val24), 32'h0);
      check("reset_err24",  32'(err24), 32'h0);
      check("reset_ser24",  32'(oser24), 32'h0);
      check("reset_led32",  get_led(1), 32'h0);
      check("reset_val32",  32'(val32), 32'h0);
      check("reset_err32",  32'(err32), 32'h0);
      check("reset_ser32",  32'(oser32), 32'h0);
      rst = 1'b0;

      // Nominal pixel with fixed 7/14 clock highs.
      send_word(0, 32'h00A5C33C, 24, 1'b1, -1, 0, 10);
      #2;
      check("pixel1_led", get_led(0), 32'h00A5C33C);
      check("pixel1_err", 32'(err24), 32'h0);

      // A second pixel's worth of bits is forwarded, not stored.
      w = $urandom & 32'h00FFFFFF;
      send_word(0, w, 24, 1'b0, -1, 0, 1000);
      #2;
      check("forward_led_held", get_led(0), 32'h00A5C33C);
      check("forward_err", 32'(err24), 32'(merr[0]));

      // Window edges: 4,10 decode as 0 and 11,17 as 1.
      for (int k = 0; k < 24; k++) begin
         int hi;
         if (k == 0)      hi = 4;
         else if (k == 1) hi = 10;
         else if (k == 2) hi = 11;
         else if (k == 3) hi = 17;
         else             hi = rand_hi(0, logic'($urandom_range(1, 0)));
         send_pulse(0, hi, (k == 23) ? 1000 : int'($urandom_range(20, 4)));
      end
      #2;
      check("boundary_top_bits", 32'(led24[23:20]), 32'h3);
      check("boundary_err", 32'(err24), 32'h0);

      // A 999-clock low between bits is not a latch gap.
      w = $urandom & 32'h00FFFFFF;
      send_word(0, w, 24, 1'b0, 5, 999, 1000);
      #2;
      check("long_low_led", get_led(0), w);
      check("long_low_err", 32'(err24), 32'h0);

      // Partial frame then a real gap: error, display held, next frame aligned.
      send_word(0, $urandom, 10, 1'b0, -1, 0, 1000);
      #2;
      check("partial_err", 32'(err24), 32'h1);
      check("partial_led_held", get_led(0), w);
      w = $urandom & 32'h00FFFFFF;
      send_word(0, w, 24, 1'b0, -1, 0, 1000);
      #2;
      check("after_partial_led", get_led(0), w);

      // Out-of-window highs of 3 and 18 store 0 and raise the error.
      do_reset();
      check("err_cleared_by_rst", 32'(err24), 32'h0);
      for (int k = 0; k < 24; k++) begin
         int hi;
         if (k == 0)      hi = 3;
         else if (k == 1) hi = 18;
         else             hi = rand_hi(0, logic'($urandom_range(1, 0)));
         send_pulse(0, hi, (k == 23) ? 1000 : int'($urandom_range(20, 4)));
      end
      #2;
      check("bad_pulse_err", 32'(err24), 32'h1);
      check("bad_pulse_top_bits", 32'(led24[23:22]), 32'h0);
      check("bad_pulse_err_model", 32'(err24), 32'(merr[0]));

      // 32-bit GRBW node at 20 ns clock.
      send_word(1, 32'h12345678, 32, 1'b1, -1, 0, 10);
      #2;
      check("grbw_led", get_led(1), 32'h12345678);
      check("grbw_err", 32'(err32), 32'h0);

      // Asynchronous reset while forwarding a high pulse.
      @(posedge clk);
      #1 ser32 = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("grbw_forward", 32'(oser32), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ser32", 32'(oser32), 32'h0);
      check("async_rst_led32", led32, 32'h0);
      check("async_rst_val32", 32'(val32), 32'h0);
      check("async_rst_err32", 32'(err32), 32'h0);
      ser32 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      repeat (10) @(posedge clk);

      check("q24_drained", 32'(q24.size()), 32'h0);
      check("q32_drained", 32'(q32.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
